// File: rtl/vector_seq_ctrl_if.sv
// Signal bundle between vector_seq_ctrl, its upstream source, the vector FIFO and the downstream MAC.
// slave = controller view, master = environment (source, FIFO, sink) view.
interface vector_seq_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 4
);
  logic              start;
  logic [LEN_W-1:0]  N;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              fifo_push;
  logic              fifo_pop;
  logic [DATA_W-1:0] fifo_data_in;
  logic              fifo_clr;
  logic [LEN_W-1:0]  fifo_N;
  logic [DATA_W-1:0] fifo_data_out;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_eop;
  logic              out_last;
  logic              busy;
  logic              done;

  modport slave (
    input  start, N, in_valid, in_data, fifo_data_out,
    output in_ready, fifo_push, fifo_pop, fifo_data_in, fifo_clr, fifo_N,
           out_valid, out_data, out_eop, out_last, busy, done
  );

  modport master (
    output start, N, in_valid, in_data, fifo_data_out,
    input  in_ready, fifo_push, fifo_pop, fifo_data_in, fifo_clr, fifo_N,
           out_valid, out_data, out_eop, out_last, busy, done
  );
endinterface

// File: rtl/vector_seq_ctrl.sv
// Loads an N-element vector into an external FIFO, then replays it N times (N*N beats)
// to a downstream MAC, marking pass ends and the final beat, and clears the FIFO when done.
module vector_seq_ctrl #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  vector_seq_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LOAD, REPLAY, DRAIN, CLEAR, DONE} state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] n_q, n_d;
  logic [LEN_W-1:0] elem_cnt_q, elem_cnt_d;
  logic [LEN_W-1:0] pass_cnt_q, pass_cnt_d;
  logic             out_valid_q, out_valid_d;
  logic             out_eop_q, out_eop_d;
  logic             out_last_q, out_last_d;

  logic [LEN_W-1:0] n_last;
  logic             elem_wrap;
  logic             pass_wrap;
  logic             load_push;
  logic             replay_pop;

  assign n_last     = n_q - LEN_W'(1);
  assign elem_wrap  = (elem_cnt_q == n_last);
  assign pass_wrap  = (pass_cnt_q == n_last);
  assign load_push  = (state_q == LOAD) && bus.in_valid;
  assign replay_pop = (state_q == REPLAY);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      n_q         <= '0;
      elem_cnt_q  <= '0;
      pass_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_eop_q   <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      elem_cnt_q  <= elem_cnt_d;
      pass_cnt_q  <= pass_cnt_d;
      out_valid_q <= out_valid_d;
      out_eop_q   <= out_eop_d;
      out_last_q  <= out_last_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    elem_cnt_d = elem_cnt_q;
    pass_cnt_d = pass_cnt_q;
    // Beat flags follow the pop by one cycle, matching the FIFO read latency.
    out_valid_d = replay_pop;
    out_eop_d   = replay_pop && elem_wrap;
    out_last_d  = replay_pop && elem_wrap && pass_wrap;

    case (state_q)
      IDLE: begin
        if (bus.start && (bus.N != '0)) begin
          n_d        = bus.N;
          elem_cnt_d = '0;
          pass_cnt_d = '0;
          state_d    = LOAD;
        end
      end
      LOAD: begin
        if (load_push) begin
          if (elem_wrap) begin
            elem_cnt_d = '0;
            state_d    = REPLAY;
          end else begin
            elem_cnt_d = elem_cnt_q + LEN_W'(1);
          end
        end
      end
      REPLAY: begin
        if (elem_wrap) begin
          elem_cnt_d = '0;
          pass_cnt_d = pass_cnt_q + LEN_W'(1);
          if (pass_wrap) begin
            state_d = DRAIN;
          end
        end else begin
          elem_cnt_d = elem_cnt_q + LEN_W'(1);
        end
      end
      DRAIN:   state_d = CLEAR;
      CLEAR:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready     = (state_q == LOAD);
  assign bus.fifo_push    = load_push;
  assign bus.fifo_data_in = (state_q == LOAD) ? bus.in_data : {DATA_W{1'b0}};
  assign bus.fifo_pop     = replay_pop;
  assign bus.fifo_clr     = (state_q == CLEAR);
  assign bus.fifo_N       = n_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_data     = out_valid_q ? bus.fifo_data_out : {DATA_W{1'b0}};
  assign bus.out_eop      = out_eop_q;
  assign bus.out_last     = out_last_q;
  assign bus.busy         = (state_q != IDLE);
  assign bus.done         = (state_q == DONE);
endmodule

// File: tb/tb_vector_seq_ctrl.sv
// Randomized bench for vector_seq_ctrl: drives jobs, emulates the vector FIFO, and compares
// every replayed beat against a pass-by-pass expansion of the loaded vector.
module tb_vector_seq_ctrl;
  localparam int DATA_W = 8;
  localparam int LEN_W  = 4;
  localparam int MEM_SZ = 8192;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;

  vector_seq_ctrl_if #(.DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

  vector_seq_ctrl #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Vector FIFO emulation: registered read, pop address wraps at fifo_N.
  logic [DATA_W-1:0] fifo_mem [16];
  logic [LEN_W-1:0]  wr_ptr;
  logic [LEN_W-1:0]  rd_ptr;
  always @(posedge clk) begin
    if (rst || bus.fifo_clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (bus.fifo_push) begin
        fifo_mem[wr_ptr] <= bus.fifo_data_in;
        wr_ptr <= wr_ptr + LEN_W'(1);
      end
      if (bus.fifo_pop) begin
        bus.fifo_data_out <= fifo_mem[rd_ptr];
        rd_ptr <= (rd_ptr == bus.fifo_N - LEN_W'(1)) ? '0 : rd_ptr + LEN_W'(1);
      end
    end
  end

  // Monitor: counts strobes and logs pushed data and output beats.
  int push_cnt = 0, pop_cnt = 0, overlap_cnt = 0, clr_cnt = 0, done_cnt = 0;
  int busy_cnt = 0, eop_cnt = 0, last_cnt = 0, beat_cnt = 0;
  int last_push_cyc = 0, pop_rise_cyc = 0, last_valid_cyc = 0, clr_cyc = 0, done_cyc = 0;
  logic prev_pop = 1'b0;
  logic [DATA_W-1:0] push_mem [MEM_SZ];
  logic [DATA_W+1:0] beat_mem [MEM_SZ];

  always @(negedge clk) begin
    prev_pop <= bus.fifo_pop & ~rst;
    if (!rst) begin
      if (bus.fifo_push) begin
        push_mem[push_cnt % MEM_SZ] <= bus.fifo_data_in;
        push_cnt      <= push_cnt + 1;
        last_push_cyc <= cyc;
      end
      if (bus.fifo_pop) begin
        pop_cnt <= pop_cnt + 1;
        if (!prev_pop) pop_rise_cyc <= cyc;
      end
      if (bus.fifo_push && bus.fifo_pop) overlap_cnt <= overlap_cnt + 1;
      if (bus.out_valid) begin
        beat_mem[beat_cnt % MEM_SZ] <= {bus.out_last, bus.out_eop, bus.out_data};
        beat_cnt       <= beat_cnt + 1;
        last_valid_cyc <= cyc;
      end
      if (bus.out_eop)  eop_cnt  <= eop_cnt + 1;
      if (bus.out_last) last_cnt <= last_cnt + 1;
      if (bus.fifo_clr) begin
        clr_cnt <= clr_cnt + 1;
        clr_cyc <= cyc;
      end
      if (bus.done) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
      end
      if (bus.busy) busy_cnt <= busy_cnt + 1;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  logic [DATA_W-1:0] job_data [16];

  task automatic make_data(input int n);
    for (int i = 0; i < n; i++) job_data[i] = DATA_W'($urandom);
  endtask

  // gap < 0: random idle cycles before each element; otherwise fixed idle cycles between elements.
  task automatic start_and_feed(input int n, input int gap);
    int g;
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.N     = LEN_W'(n);
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.N     = LEN_W'($urandom);
    for (int i = 0; i < n; i++) begin
      g = (gap < 0) ? int'($urandom_range(0, 3)) : ((i == 0) ? 0 : gap);
      bus.in_valid = 1'b0;
      bus.in_data  = DATA_W'($urandom);
      repeat (g) begin @(posedge clk); #1; end
      bus.in_valid = 1'b1;
      bus.in_data  = job_data[i];
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic run_job(input int n, input int gap, input bit extra_start);
    int push0, pop0, beat0, clr0, done0, eop0, last0, ov0, t, k;
    logic [DATA_W+1:0] exp_beat;
    push0 = push_cnt; pop0 = pop_cnt; beat0 = beat_cnt; clr0 = clr_cnt;
    done0 = done_cnt; eop0 = eop_cnt; last0 = last_cnt; ov0 = overlap_cnt;
    start_and_feed(n, gap);
    if (extra_start) begin
      t = 0;
      while (!bus.fifo_pop && t < 50) begin @(posedge clk); #1; t++; end
      check("replay_start_timeout", 32'(t < 50), 32'd1);
      bus.start = 1'b1;
      bus.N     = LEN_W'(5);
      @(posedge clk); #1;
      bus.start = 1'b0;
      check("fifo_N_after_restart", 32'(bus.fifo_N), 32'(n));
    end
    t = 0;
    while (done_cnt == done0 && t < 1000) begin @(posedge clk); #1; t++; end
    check("done_timeout", 32'(t < 1000), 32'd1);

    check("push_count", 32'(push_cnt - push0), 32'(n));
    for (int i = 0; i < n; i++)
      check("push_data", 32'(push_mem[(push0 + i) % MEM_SZ]), 32'(job_data[i]));
    check("pop_count", 32'(pop_cnt - pop0), 32'(n * n));
    check("beat_count", 32'(beat_cnt - beat0), 32'(n * n));
    k = 0;
    for (int p = 0; p < n; p++) begin
      for (int i = 0; i < n; i++) begin
        exp_beat = {(p == n - 1) && (i == n - 1), i == n - 1, job_data[i]};
        check("beat", 32'(beat_mem[(beat0 + k) % MEM_SZ]), 32'(exp_beat));
        k++;
      end
    end
    check("eop_count", 32'(eop_cnt - eop0), 32'(n));
    check("last_count", 32'(last_cnt - last0), 32'd1);
    check("push_pop_overlap", 32'(overlap_cnt - ov0), 32'd0);
    check("clr_count", 32'(clr_cnt - clr0), 32'd1);
    check("done_count", 32'(done_cnt - done0), 32'd1);
    check("replay_after_last_push", 32'(pop_rise_cyc), 32'(last_push_cyc + 1));
    check("clr_after_drain", 32'(clr_cyc), 32'(last_valid_cyc + 1));
    check("done_after_clr", 32'(done_cyc), 32'(clr_cyc + 1));
    check("fifo_N_hold", 32'(bus.fifo_N), 32'(n));
    check("busy_after_done", 32'(bus.busy), 32'd0);
    $display("job N=%0d gap=%0d restart=%0d: %0d pushes, %0d pops, %0d beats",
             n, gap, extra_start, push_cnt - push0, pop_cnt - pop0, beat_cnt - beat0);
  endtask

  initial begin
    int busy0, push0, pop0, done0, clr0, t;
    bus.start    = 1'b0;
    bus.N        = '0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;

    #1 rst = 1'b1;
    #1;
    check("rst_in_ready",     32'(bus.in_ready), 32'd0);
    check("rst_fifo_push",    32'(bus.fifo_push), 32'd0);
    check("rst_fifo_pop",     32'(bus.fifo_pop), 32'd0);
    check("rst_fifo_clr",     32'(bus.fifo_clr), 32'd0);
    check("rst_out_valid",    32'(bus.out_valid), 32'd0);
    check("rst_out_eop",      32'(bus.out_eop), 32'd0);
    check("rst_out_last",     32'(bus.out_last), 32'd0);
    check("rst_busy",         32'(bus.busy), 32'd0);
    check("rst_done",         32'(bus.done), 32'd0);
    check("rst_fifo_N",       32'(bus.fifo_N), 32'd0);
    check("rst_fifo_data_in", 32'(bus.fifo_data_in), 32'd0);
    check("rst_out_data",     32'(bus.out_data), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Directed N=3 vector 11,22,33 back-to-back.
    job_data[0] = 8'h11; job_data[1] = 8'h22; job_data[2] = 8'h33;
    run_job(3, 0, 1'b0);

    // N=2 with idle cycles between elements.
    make_data(2);
    run_job(2, 2, 1'b0);

    // start with N=0 must be ignored.
    busy0 = busy_cnt; push0 = push_cnt; pop0 = pop_cnt; done0 = done_cnt;
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.N     = '0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("n0_busy",  32'(busy_cnt - busy0), 32'd0);
    check("n0_push",  32'(push_cnt - push0), 32'd0);
    check("n0_pop",   32'(pop_cnt - pop0), 32'd0);
    check("n0_done",  32'(done_cnt - done0), 32'd0);
    $display("job N=0: busy cycles %0d", busy_cnt - busy0);

    // A second start during REPLAY must not disturb the running job.
    make_data(4);
    run_job(4, -1, 1'b1);

    // Asynchronous reset on the second replay pass.
    make_data(3);
    pop0 = pop_cnt; clr0 = clr_cnt;
    start_and_feed(3, -1);
    t = 0;
    while ((pop_cnt - pop0) < 4 && t < 100) begin @(posedge clk); #1; t++; end
    check("pass2_timeout", 32'(t < 100), 32'd1);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_fifo_pop",  32'(bus.fifo_pop), 32'd0);
    check("midrst_busy",      32'(bus.busy), 32'd0);
    check("midrst_fifo_N",    32'(bus.fifo_N), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("midrst_no_clr", 32'(clr_cnt - clr0), 32'd0);
    $display("job N=3 reset after %0d pops", pop_cnt - pop0);
    make_data(1);
    run_job(1, -1, 1'b0);

    // Randomized jobs, then the largest vector.
    for (int j = 0; j < 6; j++) begin
      make_data(15);
      run_job(int'($urandom_range(1, 15)), -1, 1'(j % 2));
    end
    make_data(15);
    run_job(15, -1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/vector_seq_ctrl.md
VECTOR_SEQ_CTRL -- requirements
Module: vector_seq_ctrl

Interface
REQ-001 Parameter DATA_W, default 8, width of each vector element; SHALL match data_t of the vector FIFO.
REQ-002 Parameter LEN_W, default 4, width of vector length N; SHALL match nibble_t.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 start  input  1  one-cycle pulse that begins a load/replay job.
REQ-006 N  input  LEN_W  vector length and replay pass count, sampled on an accepted start.
REQ-007 in_valid  input  1  upstream element valid.
REQ-008 in_data  input  DATA_W  upstream element.
REQ-009 in_ready  output  1  controller accepts an element when in_valid is also 1.
REQ-010 fifo_push  output  1  push strobe to the vector FIFO.
REQ-011 fifo_pop  output  1  pop strobe to the vector FIFO.
REQ-012 fifo_data_in  output  DATA_W  write data to the FIFO.
REQ-013 fifo_clr  output  1  pointer clear to the FIFO.
REQ-014 fifo_N  output  LEN_W  latched N driven to the FIFO pointers.
REQ-015 fifo_data_out  input  DATA_W  FIFO read data, valid 1 cycle after fifo_pop.
REQ-016 out_valid  output  1  out_data valid to downstream MAC (no backpressure).
REQ-017 out_data  output  DATA_W  replayed element.
REQ-018 out_eop  output  1  marks last element of each replay pass.
REQ-019 out_last  output  1  marks last element of the final pass.
REQ-020 busy  output  1  high in every state except IDLE.
REQ-021 done  output  1  one-cycle completion pulse.

Function
REQ-022 FSM states SHALL be IDLE, LOAD, REPLAY, DRAIN, CLEAR, DONE.
REQ-023 IDLE: start=1 and N!=0 -> latch N into n_q, clear elem_cnt and pass_cnt, go LOAD next cycle; start with N=0 SHALL be ignored.
REQ-024 start in any state other than IDLE SHALL be ignored.
REQ-025 LOAD: in_ready=1; fifo_push = in_valid & in_ready (combinational); fifo_data_in = in_data (combinational); each push increments elem_cnt.
REQ-026 LOAD: on the push with elem_cnt==n_q-1, elem_cnt SHALL clear and the FSM SHALL go REPLAY next cycle; in_ready SHALL be 0 outside LOAD.
REQ-027 REPLAY: fifo_pop=1 every cycle; each pop increments elem_cnt; at elem_cnt==n_q-1 elem_cnt clears and pass_cnt increments.
REQ-028 The FIFO pop address wraps at N, so each pass re-reads the same N elements in push order.
REQ-029 REPLAY: on the pop with elem_cnt==n_q-1 and pass_cnt==n_q-1, go DRAIN; exactly N*N pops SHALL occur per job.
REQ-030 out_valid SHALL be fifo_pop delayed by one register; out_data = fifo_data_out combinationally while out_valid=1, else 0.
REQ-031 out_eop and out_last SHALL be registered alongside out_valid: eop on every pass-final pop, last only on the final pop of the job.
REQ-032 DRAIN: one cycle, no pop, lets the final out_valid emerge; then CLEAR.
REQ-033 CLEAR: fifo_clr=1 for exactly one cycle; then DONE.
REQ-034 DONE: done=1 for exactly one cycle; then IDLE.
REQ-035 fifo_N SHALL drive n_q at all times; n_q SHALL hold until the next accepted start.
REQ-036 Counters SHALL be LEN_W bits; since N <= 2^LEN_W-1, they never overflow.
REQ-037 fifo_push and fifo_pop SHALL never be 1 in the same cycle.

Reset
REQ-038 rst=1 SHALL force IDLE immediately and clear n_q, elem_cnt, pass_cnt and all output registers, with no clock edge required.
REQ-039 During and after reset: in_ready, fifo_push, fifo_pop, fifo_clr, out_valid, out_eop, out_last, busy and done = 0; fifo_N, fifo_data_in and out_data = 0.
REQ-040 Reset mid-job SHALL abandon the job without issuing fifo_clr; the FIFO is cleared by its own reset.

Verification
REQ-041 N=3, start, feed 0x11,0x22,0x33 back-to-back -> 3 pushes, then 9 out_valid cycles 11,22,33,11,22,33,11,22,33; out_eop on elements 3, 6 and 9; out_last on element 9 only; fifo_clr, then done.
REQ-042 N=2 with in_valid gaps (valid on cycles 1, 4) -> pushes only on valid cycles; REPLAY begins the cycle after the second push; outputs A,B,A,B.
REQ-043 start with N=0 -> busy stays 0 and no push, pop or done.
REQ-044 Second start during REPLAY with N=5 -> ignored; job completes with the original N; fifo_N unchanged.
REQ-045 rst asserted mid-REPLAY on pass 2 -> same cycle: out_valid, fifo_pop and busy = 0; next start with N=1 runs 1 push, 1 pop, done.
REQ-046 N=15 full run -> exactly 15 pushes, 225 pops, 15 out_eop pulses and 1 out_last; push and pop never overlap.
